// File: rtl/mac_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module   : mac_tcdm_responder
// Brief    : Multi-port, word-interleaved banked TCDM slave with per-bank
//            round-robin arbitration and a fixed one-cycle response.
// Revision : 1.0 - initial release
// ============================================================================
module mac_tcdm_responder #(
  parameter int unsigned MP        = 4,
  parameter int unsigned NB        = 4,
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h1C01_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [MP-1:0]       tcdm_req_i,
  output logic [MP-1:0]       tcdm_gnt_o,
  input  logic [MP*32-1:0]    tcdm_add_i,
  input  logic [MP-1:0]       tcdm_wen_i,
  input  logic [MP*4-1:0]     tcdm_be_i,
  input  logic [MP*32-1:0]    tcdm_data_i,
  output logic [MP*32-1:0]    tcdm_r_data_o,
  output logic [MP-1:0]       tcdm_r_valid_o,
  input  logic [MP-1:0]       stall_i,
  output logic [MP-1:0]       err_o
);

  localparam int unsigned c_log_nb = $clog2(NB);
  localparam int unsigned c_bank_w = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned c_row_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_ptr_w  = (MP > 1) ? $clog2(MP) : 1;
  localparam logic [32:0] c_span   = 33'(NB) * 33'(DEPTH) * 33'd4;
  localparam logic [31:0] c_oor_rdata = 32'hDEAD_BEEF;

  // Per-port decode
  logic [31:0]         w_add   [MP];
  logic [31:0]         w_wdata [MP];
  logic [3:0]          w_be    [MP];
  logic [c_bank_w-1:0] w_bank  [MP];
  logic [c_row_w-1:0]  w_row   [MP];
  logic [MP-1:0]       w_oor;
  logic [MP-1:0]       w_live;
  logic [MP-1:0]       w_bank_req;
  logic [MP-1:0]       w_won;

  // Per-bank arbitration
  logic [c_ptr_w-1:0]  r_ptr   [NB];
  logic [c_ptr_w-1:0]  w_win   [NB];
  logic [NB-1:0]       w_bank_gnt;
  logic [NB-1:0][31:0] w_bank_rdata;
  logic [31:0]         w_idx;

  // Response pipeline
  logic [MP-1:0]       r_valid;
  logic [MP-1:0]       r_err;
  logic [MP-1:0][31:0] r_rdata;

  for (genvar p = 0; p < MP; p++) begin : g_port
    logic [31:0] w_off;

    assign w_add[p]   = tcdm_add_i[p*32 +: 32];
    assign w_wdata[p] = tcdm_data_i[p*32 +: 32];
    assign w_be[p]    = tcdm_be_i[p*4 +: 4];
    assign w_off      = w_add[p] - BASE_ADDR;
    // Below-base addresses wrap to a huge offset, but are caught explicitly anyway
    assign w_oor[p]   = (w_add[p] < BASE_ADDR) || ({1'b0, w_off} >= c_span);
    assign w_bank[p]  = c_bank_w'((w_off >> 2) & 32'(NB - 1));
    assign w_row[p]   = c_row_w'((w_off >> (2 + c_log_nb)) & 32'(DEPTH - 1));
  end

  assign w_live     = tcdm_req_i & ~stall_i;
  assign w_bank_req = w_live & ~w_oor;

  // First live in-range requester at or after each bank's pointer wins
  always_comb begin
    w_bank_gnt = '0;
    w_idx      = '0;
    for (int b = 0; b < NB; b++) begin
      w_win[b] = '0;
      for (int k = 0; k < MP; k++) begin
        w_idx = 32'(r_ptr[b]) + 32'(k);
        if (w_idx >= MP) begin
          w_idx = w_idx - MP;
        end
        if (!w_bank_gnt[b] && w_bank_req[c_ptr_w'(w_idx)] &&
            (w_bank[c_ptr_w'(w_idx)] == c_bank_w'(b))) begin
          w_bank_gnt[b] = 1'b1;
          w_win[b]      = c_ptr_w'(w_idx);
        end
      end
    end
  end

  always_comb begin
    w_won = '0;
    for (int b = 0; b < NB; b++) begin
      if (w_bank_gnt[b]) begin
        w_won[w_win[b]] = 1'b1;
      end
    end
  end

  // Out-of-range requests never touch a bank, so they are granted unconditionally
  assign tcdm_gnt_o = w_live & (w_oor | w_won);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NB; b++) begin
        r_ptr[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (w_bank_gnt[b]) begin
          r_ptr[b] <= (w_win[b] == c_ptr_w'(MP - 1)) ? '0 : w_win[b] + 1'b1;
        end
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [31:0]        r_mem [DEPTH];
    logic [c_row_w-1:0] w_brow;
    logic               w_we;

    assign w_brow = w_row[w_win[b]];
    // Writes are blocked while reset is held so stored contents survive a reset
    assign w_we   = rst_ni & w_bank_gnt[b] & ~tcdm_wen_i[w_win[b]];

    always_ff @(posedge clk_i) begin
      if (w_we) begin
        for (int k = 0; k < 4; k++) begin
          if (w_be[w_win[b]][k]) begin
            r_mem[w_brow][8*k +: 8] <= w_wdata[w_win[b]][8*k +: 8];
          end
        end
      end
    end

    assign w_bank_rdata[b] = r_mem[w_brow];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_err   <= '0;
      r_rdata <= '0;
    end else begin
      r_valid <= tcdm_gnt_o;
      r_err   <= tcdm_gnt_o & w_oor;
      for (int p = 0; p < MP; p++) begin
        if (!tcdm_gnt_o[p] || !tcdm_wen_i[p]) begin
          r_rdata[p] <= '0;
        end else if (w_oor[p]) begin
          r_rdata[p] <= c_oor_rdata;
        end else begin
          r_rdata[p] <= w_bank_rdata[w_bank[p]];
        end
      end
    end
  end

  assign tcdm_r_valid_o = r_valid;
  assign err_o          = r_err;
  assign tcdm_r_data_o  = r_rdata;

`ifndef SYNTHESIS
  for (genvar p = 0; p < MP; p++) begin : g_rvalid_chk
    a_rvalid_after_gnt : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      tcdm_r_valid_o[p] |-> $past(tcdm_gnt_o[p])
    );
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_tcdm_responder
// Brief    : Directed bench with a word-level reference model for the responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_tcdm_responder;

  localparam int          MP    = 4;
  localparam int          NB    = 4;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1C01_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [MP-1:0]    req, wen, stall, gnt, rvalid, err;
  logic [31:0]      add_a [MP];
  logic [31:0]      data_a [MP];
  logic [3:0]       be_a [MP];
  logic [MP*32-1:0] add_f, data_f, rdata_f;
  logic [MP*4-1:0]  be_f;

  always_comb begin
    add_f  = '0;
    data_f = '0;
    be_f   = '0;
    for (int p = 0; p < MP; p++) begin
      add_f[p*32 +: 32] = add_a[p];
      data_f[p*32 +: 32] = data_a[p];
      be_f[p*4 +: 4] = be_a[p];
    end
  end

  mac_tcdm_responder #(.MP(MP), .NB(NB), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add_f),
    .tcdm_wen_i     (wen),
    .tcdm_be_i      (be_f),
    .tcdm_data_i    (data_f),
    .tcdm_r_data_o  (rdata_f),
    .tcdm_r_valid_o (rvalid),
    .stall_i        (stall),
    .err_o          (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd(input int p);
    return rdata_f[p*32 +: 32];
  endfunction

  // Reference model: word-addressed memory, one rotating pointer per bank
  int          ptr_m [NB];
  logic [31:0] mem_m [int];
  logic [MP-1:0] exp_rv = '0, exp_err = '0, exp_known = '0;
  logic [31:0] exp_rd [MP];
  logic [MP-1:0] m_eg;
  bit          m_oor [MP];
  int          m_wd  [MP];
  longint      m_off;
  logic [31:0] m_word;

  initial for (int b = 0; b < NB; b++) ptr_m[b] = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) ptr_m[b] = 0;
      exp_rv  = '0;
      exp_err = '0;
    end
    for (int p = 0; p < MP; p++) begin
      chk($sformatf("model rvalid p%0d", p), 32'(rvalid[p]), 32'(exp_rv[p]));
      chk($sformatf("model err p%0d", p), 32'(err[p]), 32'(exp_err[p]));
      if (exp_rv[p] && exp_known[p])
        chk($sformatf("model rdata p%0d", p), rd(p), exp_rd[p]);
    end
    for (int p = 0; p < MP; p++) begin
      m_off    = longint'(add_a[p]) - longint'(BASE);
      m_oor[p] = (m_off < 0) || (m_off >= longint'(NB * DEPTH * 4));
      m_wd[p]  = m_oor[p] ? 0 : int'(m_off / 4);
    end
    m_eg = '0;
    for (int p = 0; p < MP; p++)
      if (req[p] && !stall[p] && m_oor[p]) m_eg[p] = 1'b1;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < MP; k++) begin
        int q;
        q = (ptr_m[b] + k) % MP;
        if (req[q] && !stall[q] && !m_oor[q] && (m_wd[q] % NB == b)) begin
          m_eg[q] = 1'b1;
          if (rst_n) ptr_m[b] = (q + 1) % MP;
          break;
        end
      end
    end
    chk("model gnt", 32'(gnt), 32'(m_eg));
    for (int p = 0; p < MP; p++) begin
      exp_rv[p]    = m_eg[p] && rst_n;
      exp_err[p]   = m_eg[p] && rst_n && m_oor[p];
      exp_known[p] = 1'b1;
      exp_rd[p]    = 32'h0;
      if (!wen[p]) exp_rd[p] = 32'h0;
      else if (m_oor[p]) exp_rd[p] = 32'hDEAD_BEEF;
      else if (mem_m.exists(m_wd[p])) exp_rd[p] = mem_m[m_wd[p]];
      else exp_known[p] = 1'b0;
    end
    if (rst_n) begin
      for (int p = 0; p < MP; p++) begin
        if (m_eg[p] && !m_oor[p] && !wen[p]) begin
          if (mem_m.exists(m_wd[p]) || be_a[p] == 4'hF) begin
            m_word = mem_m.exists(m_wd[p]) ? mem_m[m_wd[p]] : 32'h0;
            for (int k = 0; k < 4; k++)
              if (be_a[p][k]) m_word[8*k +: 8] = data_a[p][8*k +: 8];
            mem_m[m_wd[p]] = m_word;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
    req[p] = 1'b1; wen[p] = w; add_a[p] = a; be_a[p] = b; data_a[p] = d;
  endtask

  task automatic clr_all();
    req = '0;
  endtask

  initial begin
    req = '0; wen = '1; stall = '0;
    for (int p = 0; p < MP; p++) begin
      add_a[p] = BASE; data_a[p] = '0; be_a[p] = '0;
    end

    // Reset state
    @(negedge clk);
    chk("reset rvalid", 32'(rvalid), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset rdata", rdata_f[31:0], 32'h0);
    step();
    rst_n = 1'b1;

    // Single-port write then read
    set_port(0, 1'b0, BASE + 32'h10, 4'hF, 32'hCAFE_F00D);
    @(negedge clk); chk("wr gnt", 32'(gnt), 32'h1);
    step(); clr_all();
    @(negedge clk); chk("wr rvalid", 32'(rvalid), 32'h1); chk("wr rdata", rd(0), 32'h0);
    step(); set_port(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    @(negedge clk); chk("rd gnt", 32'(gnt), 32'h1);
    step(); clr_all();
    @(negedge clk); chk("rd rvalid", 32'(rvalid), 32'h1); chk("rd data", rd(0), 32'hCAFE_F00D);

    // Byte enables, back-to-back with read-after-write
    step(); set_port(0, 1'b0, BASE + 32'h20, 4'hF, 32'h1122_3344);
    @(negedge clk);
    step(); set_port(0, 1'b0, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD);
    @(negedge clk);
    step(); set_port(0, 1'b1, BASE + 32'h20, 4'h0, 32'h0);
    @(negedge clk);
    step(); clr_all();
    @(negedge clk); chk("be rvalid", 32'(rvalid), 32'h1); chk("be rdata", rd(0), 32'h11BB_33DD);

    // Bank 1 conflict: two full rounds, granted port drops its request
    step();
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, BASE + 32'h04 + 32'(p * 16), 4'h0, 32'h0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < MP; k++) begin
        @(negedge clk);
        chk($sformatf("conflict r%0d k%0d gnt", r, k), 32'(gnt), 32'(1 << k));
        step();
        req[k] = 1'b0;
        if (r == 0 && k == MP - 1)
          for (int p = 0; p < MP; p++) set_port(p, 1'b1, BASE + 32'h04 + 32'(p * 16), 4'h0, 32'h0);
      end
    end

    // No conflict: fill four banks in parallel, then read all four
    for (int p = 0; p < MP; p++) set_port(p, 1'b0, BASE + 32'(p * 4), 4'hF, 32'hA000_0000 + 32'(p));
    @(negedge clk); chk("nc wr gnt", 32'(gnt), 32'hF);
    step();
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, BASE + 32'(p * 4), 4'h0, 32'h0);
    @(negedge clk); chk("nc rd gnt", 32'(gnt), 32'hF);
    step(); clr_all();
    @(negedge clk); chk("nc rvalid", 32'(rvalid), 32'hF); chk("nc rdata p2", rd(2), 32'hA000_0002);

    // Stall on port 2, plus out-of-range accesses below and above the window
    step();
    stall[2] = 1'b1;
    set_port(2, 1'b1, BASE + 32'h08, 4'h0, 32'h0);
    set_port(0, 1'b1, BASE - 32'h4, 4'h0, 32'h0);
    set_port(1, 1'b0, BASE + 32'h1000, 4'hF, 32'h1234_5678);
    @(negedge clk); chk("stall1 gnt", 32'(gnt), 32'h3);
    step(); req[0] = 1'b0; req[1] = 1'b0;
    @(negedge clk);
    chk("oor err", 32'(err), 32'h3);
    chk("oor rd data", rd(0), 32'hDEAD_BEEF);
    chk("oor wr data", rd(1), 32'h0);
    chk("stall2 gnt", 32'(gnt), 32'h0);
    step();
    @(negedge clk); chk("stall3 gnt", 32'(gnt), 32'h0);
    step(); stall[2] = 1'b0;
    @(negedge clk); chk("release gnt", 32'(gnt), 32'h4);
    step(); clr_all();
    @(negedge clk); chk("release rdata", rd(2), 32'hA000_0002);
    step(); set_port(3, 1'b1, BASE, 4'h0, 32'h0);
    @(negedge clk);
    step(); clr_all();
    @(negedge clk); chk("oor wr discarded", rd(3), 32'hA000_0000);

    // Reset during a granted read
    step();
    set_port(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk); chk("rst cycle gnt", 32'(gnt), 32'h1);
    step(); rst_n = 1'b1; clr_all();
    @(negedge clk); chk("rst drops rvalid", 32'(rvalid), 32'h0);
    step(); set_port(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    step(); clr_all();
    @(negedge clk); chk("retained rdata", rd(0), 32'hCAFE_F00D);

    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
